// File: rtl/median_window_filter.sv
// ---------------------------------------------------------------------------
// median_window_filter
//
// Streaming sliding-window median filter. Keeps the most recent WIN accepted
// samples and, whenever an accept leaves the window full, registers the
// median of that window for the downstream consumer.
//
// The sorted copy of the window is updated incrementally on every accept:
// one instance of the oldest sample is removed, and the new sample is inserted
// at its ordered position. Both steps happen in the same cycle.
//
// Parameters:
//   DATA_W  sample width in bits (unsigned)
//   WIN     window length, odd, 3..15
//   CNT_W   width of the fill counter (derived, do not override)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   restart     synchronous window clear (same state effect as reset)
//   in_valid    upstream sample present
//   in_ready    block can take a sample this cycle
//   in_data     upstream sample value
//   out_valid   median present
//   out_ready   downstream accepts the median this cycle
//   out_median  median of the current window
//   win_full    window currently holds WIN samples
// ---------------------------------------------------------------------------
module median_window_filter #(
    parameter int DATA_W = 4,
    parameter int WIN    = 5,
    parameter int CNT_W  = $clog2(WIN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_median,
    output logic              win_full
);

    generate
        if (WIN < 3 || WIN > 15 || (WIN % 2) == 0) begin : g_bad_win
            $error("median_window_filter: WIN must be odd and within 3..15");
        end
    endgenerate

    localparam int             MID    = (WIN - 1) / 2;
    localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WIN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIN - 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic              produce;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] hist        [WIN];
    logic [DATA_W-1:0] sorted      [WIN];
    logic [DATA_W-1:0] base        [WIN];
    logic [DATA_W-1:0] next_sorted [WIN];
    logic [CNT_W-1:0]  rem_idx;
    logic [CNT_W-1:0]  base_len;
    logic [CNT_W-1:0]  pos;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Handshake decode and fill/run sequencing. reset and restart mask the
    // accept so a sample offered in that cycle is dropped.
    always_comb begin
        next_state = state;
        in_ready   = !out_valid || out_ready;
        accept     = in_valid && in_ready && !reset && !restart;
        produce    = 1'b0;
        case (state)
            FILL: begin
                if (accept && count == LAST_C) begin
                    next_state = RUN;
                    produce    = 1'b1;
                end
            end
            RUN: begin
                produce = accept;
            end
            default: begin
                next_state = FILL;
            end
        endcase
    end

    // Next sorted array. In RUN the oldest sample (history tail) is removed
    // first by closing the gap at its first match; the remaining WIN-1
    // entries then form the base for insertion. In FILL the base is the
    // currently occupied prefix. base[WIN-1] is padding so the insertion
    // shift never reads outside the array.
    always_comb begin
        rem_idx = LAST_C;
        for (int i = WIN - 1; i >= 0; i--) begin
            if (sorted[i] == hist[WIN-1]) begin
                rem_idx = CNT_W'(i);
            end
        end

        for (int i = 0; i < WIN; i++) begin
            base[i] = '0;
        end
        base_len = count;
        if (state == RUN) begin
            base_len = LAST_C;
            for (int i = 0; i < WIN - 1; i++) begin
                base[i] = (CNT_W'(i) < rem_idx) ? sorted[i] : sorted[i+1];
            end
        end else begin
            for (int i = 0; i < WIN - 1; i++) begin
                base[i] = sorted[i];
            end
        end

        pos = '0;
        for (int i = 0; i < WIN - 1; i++) begin
            if (CNT_W'(i) < base_len && base[i] < in_data) begin
                pos = pos + CNT_W'(1);
            end
        end

        next_sorted[0] = (pos == '0) ? in_data : base[0];
        for (int i = 1; i < WIN; i++) begin
            if (CNT_W'(i) < pos) begin
                next_sorted[i] = base[i];
            end else if (CNT_W'(i) == pos) begin
                next_sorted[i] = in_data;
            end else begin
                next_sorted[i] = base[i-1];
            end
        end
    end

    // Window state and the single output register. out_valid drops only on
    // a handshake with no new median behind it, so out_median is held
    // under backpressure.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count      <= '0;
            out_valid  <= 1'b0;
            out_median <= '0;
            win_full   <= 1'b0;
            for (int i = 0; i < WIN; i++) begin
                hist[i]   <= '0;
                sorted[i] <= '0;
            end
        end else begin
            if (accept) begin
                hist[0] <= in_data;
                for (int i = 1; i < WIN; i++) begin
                    hist[i] <= hist[i-1];
                end
                sorted <= next_sorted;
                if (count != WIN_C) begin
                    count <= count + CNT_W'(1);
                end
                win_full <= (count >= LAST_C);
            end
            if (produce) begin
                out_valid  <= 1'b1;
                out_median <= next_sorted[MID];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_median_window_filter.sv
// ---------------------------------------------------------------------------
// tb_median_window_filter
//
// Drives two instances (WIN=5/DATA_W=4 and WIN=7/DATA_W=8) through directed
// sequences. A scoreboard per instance keeps a reference window, pushes the
// expected median on every accept that fills the window, and pops/compares
// on every output handshake. Directed checks cover reset state, latency,
// backpressure and restart behaviour.
// ---------------------------------------------------------------------------
module tb_median_window_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_restart, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_win_full;
    logic [3:0] a_in_data, a_out_median;
    logic       b_restart, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_win_full;
    logic [7:0] b_in_data, b_out_median;

    int checks = 0;
    int errors = 0;

    logic [7:0] a_win [$];
    logic [7:0] b_win [$];
    logic [7:0] a_exp [$];
    logic [7:0] b_exp [$];
    logic [7:0] a_arr [15];
    logic [7:0] b_arr [15];
    logic       a_hold, b_hold;
    logic [7:0] a_hold_val, b_hold_val;

    median_window_filter #(.DATA_W(4), .WIN(5)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .restart    (a_restart),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_median (a_out_median),
        .win_full   (a_win_full)
    );

    median_window_filter #(.DATA_W(8), .WIN(7)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .restart    (b_restart),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_median (b_out_median),
        .win_full   (b_win_full)
    );

    // Reference median: sort a copy of the first n entries, take the middle.
    function automatic logic [7:0] median_of(input logic [7:0] w [15], input int n);
        logic [7:0] s [15];
        logic [7:0] t;
        s = w;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n - 1 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t      = s[j];
                    s[j]   = s[j+1];
                    s[j+1] = t;
                end
            end
        end
        return s[(n - 1) / 2];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one sample to instance a (sel=0) or b (sel=1) and hold it until
    // the edge that accepts it.
    task automatic applyStimulus(input bit sel, input logic [7:0] data);
        int waited;
        waited = 0;
        if (!sel) begin
            a_in_valid = 1'b1;
            a_in_data  = data[3:0];
        end else begin
            b_in_valid = 1'b1;
            b_in_data  = data;
        end
        #1;
        while (((!sel && !a_in_ready) || (sel && !b_in_ready)) && waited < 20) begin
            tick(1);
            waited++;
        end
        if (waited >= 20) begin
            checkOutput("accept_timeout", 32'(waited), 32'd0);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    // Scoreboard for instance a, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset || a_restart) begin
            a_win.delete();
            a_exp.delete();
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                checkOutput("a_hold_valid", 32'(a_out_valid), 32'd1);
                checkOutput("a_hold_median", 32'(a_out_median), 32'(a_hold_val));
            end
            a_hold     = a_out_valid && !a_out_ready;
            a_hold_val = {4'd0, a_out_median};
            if (a_out_valid && a_out_ready) begin
                checkOutput("a_pending", 32'(a_exp.size() != 0), 32'd1);
                if (a_exp.size() != 0) begin
                    checkOutput("a_median", 32'(a_out_median), 32'(a_exp.pop_front()));
                end
            end
            if (a_in_valid && a_in_ready) begin
                a_win.push_back({4'd0, a_in_data});
                if (a_win.size() > 5) void'(a_win.pop_front());
                if (a_win.size() == 5) begin
                    for (int i = 0; i < 5; i++) a_arr[i] = a_win[i];
                    a_exp.push_back(median_of(a_arr, 5));
                end
            end
        end
    end

    // Scoreboard for instance b.
    always @(negedge clk) begin
        if (reset || b_restart) begin
            b_win.delete();
            b_exp.delete();
            b_hold = 1'b0;
        end else begin
            if (b_hold) begin
                checkOutput("b_hold_median", 32'(b_out_median), 32'(b_hold_val));
            end
            b_hold     = b_out_valid && !b_out_ready;
            b_hold_val = b_out_median;
            if (b_out_valid && b_out_ready) begin
                checkOutput("b_pending", 32'(b_exp.size() != 0), 32'd1);
                if (b_exp.size() != 0) begin
                    checkOutput("b_median", 32'(b_out_median), 32'(b_exp.pop_front()));
                end
            end
            if (b_in_valid && b_in_ready) begin
                b_win.push_back(b_in_data);
                if (b_win.size() > 7) void'(b_win.pop_front());
                if (b_win.size() == 7) begin
                    for (int i = 0; i < 7; i++) b_arr[i] = b_win[i];
                    b_exp.push_back(median_of(b_arr, 7));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        a_restart   = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_out_ready = 1'b1;
        b_restart   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("a_rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("a_rst_win_full", 32'(a_win_full), 32'd0);
        checkOutput("a_rst_out_median", 32'(a_out_median), 32'd0);
        checkOutput("a_rst_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("b_rst_out_valid", 32'(b_out_valid), 32'd0);
        checkOutput("b_rst_win_full", 32'(b_win_full), 32'd0);

        $display("[TB] basic stream 3,9,1,7,5,0,15");
        applyStimulus(0, 8'd3);
        checkOutput("a_fill1_valid", 32'(a_out_valid), 32'd0);
        applyStimulus(0, 8'd9);
        checkOutput("a_fill2_valid", 32'(a_out_valid), 32'd0);
        applyStimulus(0, 8'd1);
        checkOutput("a_fill3_valid", 32'(a_out_valid), 32'd0);
        applyStimulus(0, 8'd7);
        checkOutput("a_fill4_valid", 32'(a_out_valid), 32'd0);
        checkOutput("a_fill4_full", 32'(a_win_full), 32'd0);
        applyStimulus(0, 8'd5);
        checkOutput("a_first_valid", 32'(a_out_valid), 32'd1);
        checkOutput("a_first_median", 32'(a_out_median), 32'd5);
        checkOutput("a_first_full", 32'(a_win_full), 32'd1);
        applyStimulus(0, 8'd0);
        checkOutput("a_run0_median", 32'(a_out_median), 32'd5);
        applyStimulus(0, 8'd15);
        checkOutput("a_run15_valid", 32'(a_out_valid), 32'd1);
        checkOutput("a_run15_median", 32'(a_out_median), 32'd5);
        tick(1);
        checkOutput("a_single_pulse", 32'(a_out_valid), 32'd0);

        $display("[TB] duplicates");
        a_restart = 1'b1;
        tick(1);
        a_restart = 1'b0;
        checkOutput("a_restart1_full", 32'(a_win_full), 32'd0);
        applyStimulus(0, 8'd4);
        applyStimulus(0, 8'd4);
        applyStimulus(0, 8'd4);
        applyStimulus(0, 8'd1);
        checkOutput("a_dup_fill_valid", 32'(a_out_valid), 32'd0);
        applyStimulus(0, 8'd1);
        checkOutput("a_dup_median0", 32'(a_out_median), 32'd4);
        applyStimulus(0, 8'd1);
        checkOutput("a_dup_median1", 32'(a_out_median), 32'd1);
        applyStimulus(0, 8'd1);
        checkOutput("a_dup_median2", 32'(a_out_median), 32'd1);

        $display("[TB] backpressure");
        a_restart = 1'b1;
        tick(1);
        a_restart = 1'b0;
        applyStimulus(0, 8'd3);
        applyStimulus(0, 8'd9);
        applyStimulus(0, 8'd1);
        applyStimulus(0, 8'd7);
        applyStimulus(0, 8'd5);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 4'd0;
        #1;
        checkOutput("a_bp_in_ready", 32'(a_in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checkOutput("a_bp_valid", 32'(a_out_valid), 32'd1);
            checkOutput("a_bp_median", 32'(a_out_median), 32'd5);
            checkOutput("a_bp_in_ready_hold", 32'(a_in_ready), 32'd0);
        end
        a_out_ready = 1'b1;
        tick(1);
        a_in_valid = 1'b0;
        checkOutput("a_bp_after_valid", 32'(a_out_valid), 32'd1);
        checkOutput("a_bp_after_median", 32'(a_out_median), 32'd5);

        $display("[TB] restart in RUN with sample offered");
        a_restart  = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 4'd15;
        tick(1);
        a_restart  = 1'b0;
        a_in_valid = 1'b0;
        checkOutput("a_rs_valid", 32'(a_out_valid), 32'd0);
        checkOutput("a_rs_full", 32'(a_win_full), 32'd0);
        applyStimulus(0, 8'd2);
        applyStimulus(0, 8'd2);
        applyStimulus(0, 8'd8);
        applyStimulus(0, 8'd8);
        checkOutput("a_rs_fill_valid", 32'(a_out_valid), 32'd0);
        applyStimulus(0, 8'd8);
        checkOutput("a_rs_median_valid", 32'(a_out_valid), 32'd1);
        checkOutput("a_rs_median", 32'(a_out_median), 32'd8);
        tick(1);
        checkOutput("a_rs_single_pulse", 32'(a_out_valid), 32'd0);

        $display("[TB] WIN=7 DATA_W=8 stream");
        applyStimulus(1, 8'd200);
        applyStimulus(1, 8'd10);
        applyStimulus(1, 8'd255);
        applyStimulus(1, 8'd0);
        applyStimulus(1, 8'd128);
        applyStimulus(1, 8'd64);
        checkOutput("b_fill_valid", 32'(b_out_valid), 32'd0);
        applyStimulus(1, 8'd90);
        checkOutput("b_first_median", 32'(b_out_median), 32'd90);
        checkOutput("b_first_full", 32'(b_win_full), 32'd1);
        applyStimulus(1, 8'd255);
        checkOutput("b_run_median", 32'(b_out_median), 32'd90);

        tick(2);
        checkOutput("a_drained", 32'(a_exp.size()), 32'd0);
        checkOutput("b_drained", 32'(b_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/median_window_filter.md
Name: median_window_filter

Overview:
- Streaming sliding-window median filter: parametrised successor to the fixed 5-input combinational median finders.
- Accepts one sample per handshake and keeps the last WIN samples.
- After each accepted sample, once the window is full, emits the median of those WIN samples.
- Sits between a sample source and downstream consumer; ready/valid on both sides with full backpressure.

Parameters:
- DATA_W, 4, sample width in bits; unsigned.
- WIN, 5, window length; odd, 3..15. Other values are illegal and must be rejected at elaboration.
- CNT_W, $clog2(WIN+1), width of internal fill counter. Derived; not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- restart  input  1  synchronous window clear; same effect as reset on state, no effect on parameters.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  sample value.
- out_valid  output  1  median present.
- out_ready  input  1  consumer accepts median this cycle.
- out_median  output  DATA_W  median of current window.
- win_full  output  1  window holds WIN samples.

Behaviour:
- Reset and restart (sampled at clk edge) set all of the following to 0:
  - out_valid, out_median, win_full
  - fill count
  - history shift register
  - sorted array
- in_ready is 1 in the first cycle after reset deasserts.
- reset and restart dominate any simultaneous handshake. A sample presented in that cycle is dropped; a pending median is discarded.
- Accept: in_valid && in_ready.
- Output: out_valid && out_ready.
- in_ready = !out_valid || out_ready. Single output register; no skid buffer; combinational path out_ready->in_ready is allowed.
- Internal state:
  - history shift register of WIN entries (oldest at tail)
  - sorted array of WIN entries, ascending
  - fill count
- States:
  - FILL (count < WIN)
  - RUN (count == WIN)
- FILL on accept:
  - Insert sample into sorted array at its ordered position among the first count entries.
  - Push sample into history; count++.
  - Reaching WIN moves to RUN.
- RUN on accept:
  - Remove exactly one entry equal to history tail (the oldest sample) from the sorted array.
  - Insert the new sample in order, in the same cycle.
  - Shift history.
  - count saturates at WIN; no wrap.
- Ties: equal values are kept as separate entries. Removal deletes exactly one instance. The order among equals is irrelevant to the result.
- Median = sorted[(WIN-1)/2] of the updated array.
- Latency: sample accepted at edge t produces out_valid=1 with out_median after edge t, when the accept yields a full window. Equivalently, the registered result is visible the cycle after the accept.
- No output during FILL, except on the accept that makes count == WIN.
- Every RUN accept produces exactly one median. No sample is lost or duplicated under backpressure.
- out_median holds its value while out_valid && !out_ready. out_median is stable otherwise until the next produced median.
- win_full = (count == WIN), registered.
- All comparisons are unsigned. No arithmetic widening; out_median is always one of the window samples.
- restart asserted in RUN:
  - The next median appears only after WIN new accepts.
  - Samples received before restart never contribute.

Test Plan:
- WIN=5, DATA_W=4: accept 3,9,1,7,5 back-to-back with out_ready=1.
  - No out_valid for the first four samples.
  - out_valid=1, out_median=5 one cycle after the 5th accept; win_full=1.
- Continue the same stream with 0, then 15.
  - Window {9,1,7,5,0} -> 5.
  - Window {1,7,5,0,15} -> 5.
  - Exactly one out_valid pulse per accept.
- Duplicates, WIN=5: 4,4,4,1,1 -> 4; then 1 -> window {4,4,1,1,1} -> 1; then 1 -> {4,1,1,1,1} -> 1.
- Backpressure: hold out_ready=0 after the first median.
  - out_median stays 5 and in_ready=0.
  - in_valid held with 0 is not accepted until out_ready=1.
  - Then out_median=5 for window {9,1,7,5,0}.
- restart pulse in RUN, with in_valid also high that cycle.
  - Next cycle: out_valid=0, win_full=0; the sample is dropped.
  - Feed 2,2,8,8,8 -> single median 8 after the 5th accept.
- WIN=7, DATA_W=8: 200,10,255,0,128,64,90 -> 90; then 255 -> window {10,255,0,128,64,90,255} -> 90.
